ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-master arbiter that shares the single-port data RAM between the core load/store port (M0) and the DMA/debug port (M1). It drives the RAM's write enable, address and write data, and returns registered read data with a one-cycle valid pulse. Arbitration is round-robin. A lock lets one master keep the RAM for a multi-beat transfer, and a hold limit bounds how long the lock can starve the other master. It sits between the bus interconnect and the RAM.

## Interface
- ADDR_W, 32, byte address width; the RAM is word-indexed by addr[ADDR_W-1:2]
- DATA_W, 32, data width
- MAX_HOLD, 16, maximum consecutive locked cycles before a forced release (≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_req_i / m1_req_i  in  1  access request, held until granted
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_lock_i / m1_lock_i  in  1  keep ownership after this beat
- m0_addr_i / m1_addr_i  in  ADDR_W  byte address
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m0_gnt_o / m1_gnt_o  out  1  access issued to the RAM this cycle
- m0_rvalid_o / m1_rvalid_o  out  1  read data valid, one-cycle pulse
- m0_rdata_o / m1_rdata_o  out  DATA_W  registered read data
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM combinational read data

## Operation
- State: owner ∈ {NONE, M0, M1}, last ∈ {M0, M1}, hold_cnt (width clog2(MAX_HOLD)+1).
- **Locked case.** Applies when owner≠NONE and hold_cnt<MAX_HOLD.
  - Only the owner can be granted.
  - The other master stalls even if the owner is idle that cycle.
- **Unlocked case.** Applies when owner=NONE.
  - A single requester is granted.
  - If both request, the master ≠ last is granted.
- **Forced release.** Applies when hold_cnt=MAX_HOLD.
  - Owner is treated as NONE for that cycle.
  - The non-owner wins a tie.
  - hold_cnt clears to 0.
- **Grant side-effects.** On a grant to Mx:
  - last:=Mx.
  - ram_addr_o/ram_we_o/ram_wdata_o come from Mx.
  - If Mx_lock_i=1, owner:=Mx; otherwise owner:=NONE.
- **hold_cnt.**
  - Increments every cycle owner≠NONE, saturating at MAX_HOLD.
  - Clears when owner becomes NONE or changes.
- **Lock drop by an idle owner.** If the owner deasserts lock_i without a request, owner:=NONE the next cycle.
- **No grant.** ram_we_o=0, ram_addr_o=0, ram_wdata_o=0.
- **Read grant.** At the clock edge, ram_rdata_i is captured into Mx_rdata_o and Mx_rvalid_o=1 for exactly the next cycle.
  - Mx_rdata_o holds its value until Mx's next read.
- **Write grant.** The RAM commits at the same edge; no rvalid is produced.
- **Ordering.** A write followed by a read to the same address returns the new data.

## Timing
- Grant is combinational from req_i and the registered state, in the same cycle. Zero added latency for writes.
- Read latency is 1 cycle: gnt in cycle N, rvalid/rdata in cycle N+1.
- Back-to-back grants every cycle are allowed; throughput is 1 access per cycle.
- Reset values:
  - all gnt_o=0, all rvalid_o=0, all rdata_o=0
  - owner=NONE, last=M1 (so M0 wins the first tie), hold_cnt=0
  - RAM outputs 0
- Reset asserted in the same cycle as a read grant: no rvalid is produced after reset.
- Requests present during rst are ignored.
- A request while the other master is locked stays pending with gnt=0. No request is dropped.

## Structure
- Shared package holds:
  - owner encoding (OWN_NONE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2)
  - ZERO_WORD
  - default MAX_HOLD
- One sub-module, rr_arb2: a two-requester round-robin pick given req[1:0], last and a force-mask; outputs a one-hot grant.
- Mux, counter and read-data registers live in ram_arbiter.

## Test plan
- **Reset, then simultaneous reads.** Both masters read at the same cycle (M0 0x10, M1 0x20).
  - M0 is granted first, M1 on the next cycle.
  - Each rvalid arrives one cycle after its own grant with the correct word.
- **Write-then-read.** M0 writes 0xDEADBEEF to 0x40, then M1 reads 0x40 the next cycle.
  - m1_rdata_o=0xDEADBEEF.
  - No rvalid on M0.
- **Locked burst.** M1 does a 4-beat burst with lock while M0 requests continuously.
  - M0 gets gnt=0 for all 4 beats.
  - M0 is granted the cycle after M1 deasserts lock.
- **Starvation cap.** M1 holds lock with req asserted for 40 cycles, MAX_HOLD=16, while M0 requests continuously.
  - M0 is granted exactly at cycle 17.
  - M1 then re-acquires ownership.
- **Reset mid-read.** rst is asserted in the same cycle as a read grant to M0.
  - m0_rvalid_o stays 0.
  - All outputs are at their reset values the next cycle.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: owner encoding, zero word, default hold limit.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_MAX_HOLD = 16;

    localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin pick: masked requesters are ignored, a tie goes to the one that was not last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic [1:0] mask_i,
    output logic [1:0] gnt_o
);

    logic [1:0] eff_req;

    assign eff_req = req_i & ~mask_i;

    always_comb begin
        gnt_o = eff_req;
        if (eff_req == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between M0 and M1 with round-robin, lock ownership and a bounded hold.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m0_gnt_o,
    output logic              m1_gnt_o,
    output logic              m0_rvalid_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    owner_e              owner_q, owner_d;
    logic                last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                m0_rvalid_q, m1_rvalid_q;
    logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;

    logic                owned, forced, locked;
    logic [1:0]          req_vec, arb_mask, pick;
    logic                arb_last;

    // A saturated hold turns the owner into a normal contender that loses any tie.
    assign owned  = (owner_q != OWN_NONE);
    assign forced = owned && (hold_q == HOLD_MAX);
    assign locked = owned && !forced;

    assign req_vec  = {m1_req_i, m0_req_i} & {2{~rst}};
    assign arb_mask = !locked ? 2'b00 : ((owner_q == OWN_M0) ? 2'b10 : 2'b01);
    assign arb_last = forced ? (owner_q == OWN_M1) : last_q;

    rr_arb2 u_rr_arb2 (
        .req_i  (req_vec),
        .last_i (arb_last),
        .mask_i (arb_mask),
        .gnt_o  (pick)
    );

    assign m0_gnt_o    = pick[0];
    assign m1_gnt_o    = pick[1];
    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

    // RAM port follows the granted master, idles at zero otherwise.
    always_comb begin
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = DATA_W'(ZERO_WORD);
        if (pick[0]) begin
            ram_we_o    = m0_we_i;
            ram_addr_o  = m0_addr_i;
            ram_wdata_o = m0_wdata_i;
        end else if (pick[1]) begin
            ram_we_o    = m1_we_i;
            ram_addr_o  = m1_addr_i;
            ram_wdata_o = m1_wdata_i;
        end
    end

    always_comb begin
        owner_d = forced ? OWN_NONE : owner_q;
        last_d  = last_q;
        hold_d  = '0;
        if (pick[0]) begin
            last_d  = 1'b0;
            owner_d = m0_lock_i ? OWN_M0 : OWN_NONE;
        end else if (pick[1]) begin
            last_d  = 1'b1;
            owner_d = m1_lock_i ? OWN_M1 : OWN_NONE;
        end else if (locked) begin
            // Idle owner that lets go of its lock releases the RAM.
            if ((owner_q == OWN_M0 && !m0_lock_i) || (owner_q == OWN_M1 && !m1_lock_i)) begin
                owner_d = OWN_NONE;
            end
        end
        if (!forced && owner_d != OWN_NONE && owner_d == owner_q) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            last_q      <= 1'b1;
            hold_q      <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= DATA_W'(ZERO_WORD);
            m1_rdata_q  <= DATA_W'(ZERO_WORD);
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            m0_rvalid_q <= pick[0] & ~m0_we_i;
            m1_rvalid_q <= pick[1] & ~m1_we_i;
            if (pick[0] && !m0_we_i) m0_rdata_q <= ram_rdata_i;
            if (pick[1] && !m1_we_i) m1_rdata_q <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small combinational-read RAM model behind it.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [31:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req_i    (m0_req),
        .m0_we_i     (m0_we),
        .m0_lock_i   (m0_lock),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
        .m1_req_i    (m1_req),
        .m1_we_i     (m1_we),
        .m1_lock_i   (m1_lock),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
        .m0_gnt_o    (m0_gnt),
        .m1_gnt_o    (m1_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m1_rvalid_o (m1_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_rdata_o  (m1_rdata),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    // RAM model: word i preloads to A000_0000+i on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (ram_we) begin
            mem[ram_addr[7:2]] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic exp_m0;

        do_reset();
        @(negedge clk);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        tick();

        // Simultaneous reads: M0 first, M1 next cycle.
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h20;
        @(negedge clk);
        chk("tie_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("tie_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("tie_ram_addr0", ram_addr, 32'h10);
        tick();
        m0_req = 0;
        @(negedge clk);
        chk("tie_m1_gnt2", 32'(m1_gnt), 32'd1);
        chk("tie_m0_gnt2", 32'(m0_gnt), 32'd0);
        chk("tie_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("tie_m0_rdata", m0_rdata, 32'hA000_0004);
        chk("tie_ram_addr1", ram_addr, 32'h20);
        tick();
        m1_req = 0;
        @(negedge clk);
        chk("tie_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("tie_m1_rdata", m1_rdata, 32'hA000_0008);
        chk("tie_m0_rvalid_drop", 32'(m0_rvalid), 32'd0);
        tick();
        @(negedge clk);
        chk("tie_m1_rvalid_drop", 32'(m1_rvalid), 32'd0);
        chk("tie_m1_rdata_hold", m1_rdata, 32'hA000_0008);
        tick();

        // Write then read the same word.
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_addr", ram_addr, 32'h40);
        chk("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        tick();
        clear_inputs();
        m1_req = 1; m1_addr = 32'h40;
        @(negedge clk);
        chk("rd_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("wr_m0_no_rvalid", 32'(m0_rvalid), 32'd0);
        tick();
        m1_req = 0;
        @(negedge clk);
        chk("rd_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("rd_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        chk("rd_m0_no_rvalid", 32'(m0_rvalid), 32'd0);
        tick();

        // Locked 4-beat burst from M1 with M0 waiting.
        for (int b = 0; b < 4; b++) begin
            m1_req = 1; m1_we = 1; m1_lock = (b < 3); m1_addr = 32'h80 + 32'(4 * b); m1_wdata = 32'(b);
            m0_req = (b >= 1); m0_addr = 32'h4;
            @(negedge clk);
            chk($sformatf("burst_m1_gnt_b%0d", b), 32'(m1_gnt), 32'd1);
            chk($sformatf("burst_m0_gnt_b%0d", b), 32'(m0_gnt), 32'd0);
            tick();
        end
        m1_req = 0; m1_lock = 0; m1_we = 0;
        @(negedge clk);
        chk("burst_m0_gnt_after", 32'(m0_gnt), 32'd1);
        chk("burst_m1_gnt_after", 32'(m1_gnt), 32'd0);
        tick();
        clear_inputs();

        // Starvation cap: forced release at cycles 17 and 35, M1 re-acquires each time.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h60; m1_wdata = 32'(c);
            m0_req = (c >= 1 && c != 18 && c != 36); m0_addr = 32'h8;
            exp_m0 = (c == 17 || c == 35);
            @(negedge clk);
            chk($sformatf("starve_m0_gnt_c%0d", c), 32'(m0_gnt), 32'(exp_m0));
            chk($sformatf("starve_m1_gnt_c%0d", c), 32'(m1_gnt), 32'(!exp_m0));
            chk($sformatf("starve_m0_rvalid_c%0d", c), 32'(m0_rvalid), 32'(c == 18 || c == 36));
            tick();
        end
        clear_inputs();
        @(negedge clk);
        tick();

        // Reset landing on a read grant.
        m0_req = 1; m0_addr = 32'h14;
        @(negedge clk);
        chk("pre_m0_gnt", 32'(m0_gnt), 32'd1);
        tick();
        m0_req = 0;
        @(negedge clk);
        chk("pre_m0_rdata", m0_rdata, 32'hA000_0005);
        tick();
        m0_req = 1; m0_addr = 32'h10; rst = 1;
        @(negedge clk);
        chk("rstrd_m0_gnt", 32'(m0_gnt), 32'd0);
        tick();
        rst = 0; m0_req = 0;
        @(negedge clk);
        chk("rstrd_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rstrd_m0_rdata", m0_rdata, 32'd0);
        chk("rstrd_m1_rdata", m1_rdata, 32'd0);
        chk("rstrd_ram_we", 32'(ram_we), 32'd0);
        chk("rstrd_ram_addr", ram_addr, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
